axi_slave_model: RTL and testbench

- AXI4 full-protocol slave memory model. Serves the external AXI master port (MM_AXI_*) of the fmrv32im_core in the core testbench.
- Supports single-beat and INCR/FIXED/WRAP bursts with byte strobes. Reads and writes are independent, one outstanding transaction per direction.
- Backing store is a word-addressed array. Address decoding wraps modulo the array size.

---
 rtl/axi_slave_model_pkg.sv | 48 ++++
 rtl/axi_slave_mem.sv | 41 ++++
 rtl/axi_slave_model.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_slave_model.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_model_pkg.sv
// Shared encodings, FSM states and the burst address-advance helper for axi_slave_model.
package axi_slave_model_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Unsupported WRAP lengths and the reserved burst code fall back to INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] res;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    res = (addr & ~mask) | ((addr + step) & mask);
                end else begin
                    res = addr + step;
                end
            end
            default: res = addr + step;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Byte-strobed single-clock word memory: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module axi_slave_mem
    import axi_slave_model_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [0:(2**ADDR_BITS)-1];

    // Byte-lane write of the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register; holds its value when no read is requested, old data wins on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'd0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/axi_slave_model.sv
// AXI4 slave memory model with independent read/write FSMs, one transaction per direction.
// Optional AXI_SLAVE_WAIT_EN inserts LFSR-driven wait states on the handshake outputs.
module axi_slave_model
    import axi_slave_model_pkg::*;
#(
    parameter int ID_WIDTH      = 1,
    parameter int USER_WIDTH    = 1,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ID_WIDTH-1:0]   M_AXI_AWID,
    input  logic [31:0]           M_AXI_AWADDR,
    input  logic [7:0]            M_AXI_AWLEN,
    input  logic [2:0]            M_AXI_AWSIZE,
    input  logic [1:0]            M_AXI_AWBURST,
    input  logic                  M_AXI_AWLOCK,
    input  logic [3:0]            M_AXI_AWCACHE,
    input  logic [2:0]            M_AXI_AWPROT,
    input  logic [3:0]            M_AXI_AWQOS,
    input  logic [USER_WIDTH-1:0] M_AXI_AWUSER,
    input  logic                  M_AXI_AWVALID,
    output logic                  M_AXI_AWREADY,
    input  logic [31:0]           M_AXI_WDATA,
    input  logic [3:0]            M_AXI_WSTRB,
    input  logic                  M_AXI_WLAST,
    input  logic [USER_WIDTH-1:0] M_AXI_WUSER,
    input  logic                  M_AXI_WVALID,
    output logic                  M_AXI_WREADY,
    output logic [ID_WIDTH-1:0]   M_AXI_BID,
    output logic [1:0]            M_AXI_BRESP,
    output logic [USER_WIDTH-1:0] M_AXI_BUSER,
    output logic                  M_AXI_BVALID,
    input  logic                  M_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]   M_AXI_ARID,
    input  logic [31:0]           M_AXI_ARADDR,
    input  logic [7:0]            M_AXI_ARLEN,
    input  logic [2:0]            M_AXI_ARSIZE,
    input  logic [1:0]            M_AXI_ARBURST,
    input  logic [1:0]            M_AXI_ARLOCK,
    input  logic [3:0]            M_AXI_ARCACHE,
    input  logic [2:0]            M_AXI_ARPROT,
    input  logic [3:0]            M_AXI_ARQOS,
    input  logic [USER_WIDTH-1:0] M_AXI_ARUSER,
    input  logic                  M_AXI_ARVALID,
    output logic                  M_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   M_AXI_RID,
    output logic [31:0]           M_AXI_RDATA,
    output logic [1:0]            M_AXI_RRESP,
    output logic                  M_AXI_RLAST,
    output logic [USER_WIDTH-1:0] M_AXI_RUSER,
    output logic                  M_AXI_RVALID,
    input  logic                  M_AXI_RREADY
);

    wr_state_e               wr_state_r;
    logic [ID_WIDTH-1:0]     bid_r;
    logic [31:0]             waddr_r;
    logic [7:0]              wlen_r, wcnt_r;
    logic [2:0]              wsize_r;
    logic [1:0]              wburst_r, bresp_r;
    logic                    werr_r, awready_r, wready_r, bvalid_r;

    rd_state_e               rd_state_r;
    logic [ID_WIDTH-1:0]     rid_r;
    logic [31:0]             raddr_r, r_next_addr_s;
    logic [7:0]              rlen_r, rcnt_r;
    logic [2:0]              rsize_r;
    logic [1:0]              rburst_r;
    logic                    arready_r, rvalid_r, rlast_r;

    logic                    w_beat_s, w_final_s, w_last_err_s, ar_hs_s, r_beat_s, mem_re_s;
    logic [MEM_ADDR_BITS-1:0] mem_raddr_s;
    // Gate bits: [0] AWREADY, [1] WREADY, [2] ARREADY, [3] RVALID, [4] BVALID.
    logic [4:0]              gate_s;
    logic                    unused_s;

`ifdef AXI_SLAVE_WAIT_EN
    logic [7:0] lfsr_r, lfsr_next_s;
    assign lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    // Free-running wait-state LFSR; outputs are loaded from its next value so they track it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end
    assign gate_s = lfsr_next_s[4:0];
`else
    assign gate_s = 5'b11111;
`endif

    assign w_beat_s     = (wr_state_r == W_DATA) && wready_r && M_AXI_WVALID;
    assign w_final_s    = (wcnt_r == wlen_r);
    assign w_last_err_s = (M_AXI_WLAST != w_final_s);
    assign ar_hs_s      = (rd_state_r == R_IDLE) && arready_r && M_AXI_ARVALID;
    assign r_beat_s     = (rd_state_r == R_DATA) && rvalid_r && M_AXI_RREADY;
    assign r_next_addr_s = next_addr(raddr_r, rlen_r, rsize_r, rburst_r);

    // Read port: fetch on AR acceptance and on every non-final accepted beat only.
    always_comb begin
        mem_re_s    = 1'b0;
        mem_raddr_s = raddr_r[MEM_ADDR_BITS+1:2];
        if (ar_hs_s) begin
            mem_re_s    = 1'b1;
            mem_raddr_s = M_AXI_ARADDR[MEM_ADDR_BITS+1:2];
        end else if (r_beat_s && !rlast_r) begin
            mem_re_s    = 1'b1;
            mem_raddr_s = r_next_addr_s[MEM_ADDR_BITS+1:2];
        end else begin
            mem_re_s    = 1'b0;
        end
    end

    // Write FSM: address latch, data beats with WLAST checking, then response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_r <= W_IDLE;
            bid_r      <= '0;
            waddr_r    <= 32'd0;
            wlen_r     <= 8'd0;
            wcnt_r     <= 8'd0;
            wsize_r    <= 3'd0;
            wburst_r   <= 2'b00;
            bresp_r    <= RESP_OKAY;
            werr_r     <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (awready_r && M_AXI_AWVALID) begin
                        bid_r      <= M_AXI_AWID;
                        waddr_r    <= M_AXI_AWADDR;
                        wlen_r     <= M_AXI_AWLEN;
                        wsize_r    <= M_AXI_AWSIZE;
                        wburst_r   <= M_AXI_AWBURST;
                        wcnt_r     <= 8'd0;
                        werr_r     <= (M_AXI_AWBURST == BURST_WRAP) && !wrap_len_ok(M_AXI_AWLEN);
                        awready_r  <= 1'b0;
                        wready_r   <= gate_s[1];
                        wr_state_r <= W_DATA;
                    end else begin
                        awready_r  <= gate_s[0];
                    end
                end
                W_DATA: begin
                    if (w_beat_s && w_final_s) begin
                        wready_r   <= 1'b0;
                        bvalid_r   <= gate_s[4];
                        bresp_r    <= (werr_r || w_last_err_s) ? RESP_SLVERR : RESP_OKAY;
                        wr_state_r <= W_RESP;
                    end else if (w_beat_s) begin
                        wcnt_r     <= wcnt_r + 8'd1;
                        waddr_r    <= next_addr(waddr_r, wlen_r, wsize_r, wburst_r);
                        werr_r     <= werr_r || w_last_err_s;
                        wready_r   <= gate_s[1];
                    end else begin
                        wready_r   <= gate_s[1];
                    end
                end
                W_RESP: begin
                    if (bvalid_r && M_AXI_BREADY) begin
                        bvalid_r   <= 1'b0;
                        bresp_r    <= RESP_OKAY;
                        awready_r  <= gate_s[0];
                        wr_state_r <= W_IDLE;
                    end else if (!bvalid_r) begin
                        bvalid_r   <= gate_s[4];
                    end
                end
                default: begin
                    awready_r  <= 1'b0;
                    wready_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: address latch, then beats until the one flagged RLAST is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_r <= R_IDLE;
            rid_r      <= '0;
            raddr_r    <= 32'd0;
            rlen_r     <= 8'd0;
            rcnt_r     <= 8'd0;
            rsize_r    <= 3'd0;
            rburst_r   <= 2'b00;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rid_r      <= M_AXI_ARID;
                        raddr_r    <= M_AXI_ARADDR;
                        rlen_r     <= M_AXI_ARLEN;
                        rsize_r    <= M_AXI_ARSIZE;
                        rburst_r   <= M_AXI_ARBURST;
                        rcnt_r     <= 8'd0;
                        rlast_r    <= (M_AXI_ARLEN == 8'd0);
                        arready_r  <= 1'b0;
                        rvalid_r   <= gate_s[3];
                        rd_state_r <= R_DATA;
                    end else begin
                        arready_r  <= gate_s[2];
                    end
                end
                R_DATA: begin
                    if (r_beat_s && rlast_r) begin
                        rvalid_r   <= 1'b0;
                        rlast_r    <= 1'b0;
                        arready_r  <= gate_s[2];
                        rd_state_r <= R_IDLE;
                    end else if (r_beat_s) begin
                        rcnt_r     <= rcnt_r + 8'd1;
                        raddr_r    <= r_next_addr_s;
                        rlast_r    <= ((rcnt_r + 8'd1) == rlen_r);
                        rvalid_r   <= gate_s[3];
                    end else if (!rvalid_r) begin
                        rvalid_r   <= gate_s[3];
                    end
                end
                default: begin
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    axi_slave_mem #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_mem (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .we    (w_beat_s),
        .waddr (waddr_r[MEM_ADDR_BITS+1:2]),
        .wdata (M_AXI_WDATA),
        .wstrb (M_AXI_WSTRB),
        .re    (mem_re_s),
        .raddr (mem_raddr_s),
        .rdata (M_AXI_RDATA)
    );

    assign M_AXI_AWREADY = awready_r;
    assign M_AXI_WREADY  = wready_r;
    assign M_AXI_BID     = bid_r;
    assign M_AXI_BRESP   = bresp_r;
    assign M_AXI_BUSER   = {USER_WIDTH{1'b0}};
    assign M_AXI_BVALID  = bvalid_r;
    assign M_AXI_ARREADY = arready_r;
    assign M_AXI_RID     = rid_r;
    assign M_AXI_RRESP   = RESP_OKAY;
    assign M_AXI_RLAST   = rlast_r;
    assign M_AXI_RUSER   = {USER_WIDTH{1'b0}};
    assign M_AXI_RVALID  = rvalid_r;

    assign unused_s = ^{M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
                        M_AXI_WUSER, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS,
                        M_AXI_ARUSER};

endmodule

// File: tb/tb_axi_slave_model.sv
// Randomized self-checking bench for axi_slave_model against a word-array reference model.
module tb_axi_slave_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awid, awlock, awuser, awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic [3:0]  awcache, awqos;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wuser, wvalid, wready;
    logic        bid, buser, bvalid, bready;
    logic [1:0]  bresp;
    logic        arid, aruser, arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache, arqos;
    logic        rid, rlast, ruser, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int checks = 0;
    int passes = 0;
    logic [31:0] ref_mem [0:4095];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rd_log  [$];

    always #5 clk = ~clk;

    axi_slave_model dut (
        .ACLK(clk), .ARESETN(rst_n),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BUSER(buser), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Byte address of beat i, from the burst rules stated as plain arithmetic.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                              input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [31:0] step, total, base;
        step  = 32'd1 << size;
        total = step * ({24'd0, len} + 32'd1);
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            base = start - (start % total);
            return base + ((start - base + step * 32'(i)) % total);
        end
        return start + step * 32'(i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd4096);
    endfunction

    task automatic aw_phase(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit seen = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); seen = (awready === 1'b1); @(posedge clk); #1;
        end
        awvalid = 1'b0;
        checks++;
        if (!seen) $display("FAIL aw_handshake got=timeout exp=handshake");
        else passes++;
    endtask

    task automatic ar_phase(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit seen = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); seen = (arready === 1'b1); @(posedge clk); #1;
        end
        arvalid = 1'b0;
        checks++;
        if (!seen) $display("FAIL ar_handshake got=timeout exp=handshake");
        else passes++;
    endtask

    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad,
                            input bit chk);
        bit seen;
        bit wrap_bad;
        int idx;
        logic [1:0] exp_resp, got_resp;
        logic got_id;
        aw_phase(id, addr, len, size, burst);
        if (chk) begin
            checks++;
            if (wready !== 1'b1) $display("FAIL wready_latency got=%b exp=1", wready);
            else passes++;
        end
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wq_data[i]; wstrb = wq_strb[i];
            wlast = (i == int'(len)) ^ (i == bad);
            wvalid = 1'b1; seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk); seen = (wready === 1'b1); @(posedge clk); #1;
            end
            if (!seen) begin
                checks++;
                $display("FAIL w_handshake beat=%0d got=timeout exp=handshake", i);
                break;
            end
            idx = widx(beat_addr(addr, i, len, size, burst));
            for (int b = 0; b < 4; b++)
                if (wq_strb[i][b]) ref_mem[idx][b*8 +: 8] = wq_data[i][b*8 +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (chk) begin
            checks++;
            if (bvalid !== 1'b1) $display("FAIL bvalid_latency got=%b exp=1", bvalid);
            else passes++;
        end
        bready = 1'b1; seen = 1'b0; got_resp = 2'b00; got_id = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bvalid === 1'b1) begin seen = 1'b1; got_resp = bresp; got_id = bid; end
            @(posedge clk); #1;
        end
        bready = 1'b0;
        wrap_bad = (burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        exp_resp = (bad >= 0 || wrap_bad) ? 2'b10 : 2'b00;
        checks++;
        if (!seen) $display("FAIL b_channel got=timeout exp=bvalid");
        else if ({got_id, got_resp} !== {id, exp_resp})
            $display("FAIL bresp_bid got=%b/%b exp=%b/%b", got_id, got_resp, id, exp_resp);
        else passes++;
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rand_stall,
                           input int hold, input bit chk);
        int i = 0;
        int h = hold;
        bit have = 1'b0;
        logic [31:0] held = 32'd0;
        logic [31:0] exp;
        ar_phase(id, addr, len, size, burst);
        if (chk) begin
            checks++;
            if (rvalid !== 1'b1) $display("FAIL rvalid_latency got=%b exp=1", rvalid);
            else passes++;
        end
        rready = (h > 0) ? 1'b0 : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b1);
        for (int c = 0; c < 600 && i <= int'(len); c++) begin
            @(negedge clk);
            if (!rready && h > 0) begin
                if (have) begin
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== held)
                        $display("FAIL r_hold got=%b/%h exp=1/%h", rvalid, rdata, held);
                    else passes++;
                    h--;
                end else if (rvalid === 1'b1) begin
                    held = rdata; have = 1'b1; h--;
                end else begin
                    have = 1'b0;
                end
            end
            if (rvalid === 1'b1 && rready) begin
                exp = ref_mem[widx(beat_addr(addr, i, len, size, burst))];
                rd_log.push_back(rdata);
                checks++;
                if (rdata !== exp) $display("FAIL rdata beat=%0d got=%h exp=%h", i, rdata, exp);
                else passes++;
                checks++;
                if ({rid, rresp, rlast} !== {id, 2'b00, (i == int'(len))})
                    $display("FAIL rid_rresp_rlast beat=%0d got=%b/%b/%b exp=%b/00/%b",
                             i, rid, rresp, rlast, id, (i == int'(len)));
                else passes++;
                i++;
            end
            @(posedge clk); #1;
            rready = (h > 0) ? 1'b0 : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        rready = 1'b0;
        checks++;
        if (i <= int'(len)) $display("FAIL r_channel got=%0d beats exp=%0d", i, int'(len) + 1);
        else passes++;
    endtask

    task automatic fill_queue(input int n, input logic [31:0] first, input bit rnd);
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back(rnd ? $urandom : first + 32'(i));
            wq_strb.push_back(4'hF);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
            $display("FAIL reset_handshake got=%b exp=000000",
                     {awready, wready, bvalid, arready, rvalid, rlast});
        else passes++;
        checks++;
        if ({bresp, rresp, rdata, bid, rid, buser, ruser} !== 40'd0)
            $display("FAIL reset_data got=%h/%h/%h/%b/%b exp=0", bresp, rresp, rdata, bid, rid);
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            fill_queue(16, 32'd0, 1'b1);
            do_write(1'($urandom_range(0, 1)), 32'(k * 64), 8'd15, 3'd2, 2'b01, -1, 1'b0);
        end
    endtask

    task automatic test_single();
        wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
        do_write(1'b1, 32'h800, 8'd0, 3'd2, 2'b01, -1, 1'b1);
        rd_log.delete();
        do_read(1'b0, 32'h800, 8'd0, 3'd2, 2'b01, 1'b0, 0, 1'b1);
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'hDEADBEEF)
            $display("FAIL single_rdata got=%h exp=deadbeef", (rd_log.size() > 0) ? rd_log[0] : 32'hx);
        else passes++;
    endtask

    task automatic test_incr();
        fill_queue(4, 32'd1, 1'b0);
        do_write(1'b0, 32'h100, 8'd3, 3'd2, 2'b01, -1, 1'b0);
        rd_log.delete();
        do_read(1'b1, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'(i + 1)) $display("FAIL incr_beat%0d got=%h exp=%h", i, rd_log[i], i + 1);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'd3, 32'd4, 32'd1, 32'd2};
        rd_log.delete();
        do_read(1'b0, 32'h108, 8'd3, 3'd2, 2'b10, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== exp_seq[i]) $display("FAIL wrap_beat%0d got=%h exp=%h", i, rd_log[i], exp_seq[i]);
            else passes++;
        end
    endtask

    task automatic test_strobe();
        wq_data = '{32'h11223344}; wq_strb = '{4'hF};
        do_write(1'b0, 32'h180, 8'd0, 3'd2, 2'b01, -1, 1'b0);
        wq_data = '{32'hAAAA5555}; wq_strb = '{4'h3};
        do_write(1'b1, 32'h180, 8'd0, 3'd2, 2'b01, -1, 1'b0);
        rd_log.delete();
        do_read(1'b1, 32'h180, 8'd0, 3'd2, 2'b01, 1'b0, 0, 1'b0);
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'h11225555)
            $display("FAIL strobe_merge got=%h exp=11225555", (rd_log.size() > 0) ? rd_log[0] : 32'hx);
        else passes++;
    endtask

    task automatic test_protocol_err();
        fill_queue(4, 32'd0, 1'b1);
        do_write(1'b1, 32'h1C0, 8'd3, 3'd2, 2'b01, 1, 1'b0);
        fill_queue(3, 32'd0, 1'b1);
        do_write(1'b0, 32'h1D0, 8'd2, 3'd2, 2'b10, -1, 1'b0);
        do_read(1'b0, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 6, 1'b0);
    endtask

    task automatic test_reset_mid();
        ar_phase(1'b1, 32'h100, 8'd3, 3'd2, 2'b01);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rvalid, rlast, arready, awready, rdata} !== 36'd0)
            $display("FAIL reset_mid got=%b%b%b%b/%h exp=0000/0", rvalid, rlast, arready, awready, rdata);
        else passes++;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({arready, awready, rvalid, bvalid, wready} !== 5'b11000)
            $display("FAIL idle_after_reset got=%b exp=11000", {arready, awready, rvalid, bvalid, wready});
        else passes++;
        do_read(1'b0, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        int bad;
        for (int t = 0; t < 60; t++) begin
            len   = 8'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 3));
            addr  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 32'h13F));
            if ($urandom_range(0, 1) == 0) begin
                wq_data.delete(); wq_strb.delete();
                for (int i = 0; i <= int'(len); i++) begin
                    wq_data.push_back($urandom);
                    wq_strb.push_back(4'($urandom_range(0, 15)));
                end
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
                do_write(1'($urandom_range(0, 1)), addr, len, size, burst, bad, 1'b0);
            end else begin
                do_read(1'($urandom_range(0, 1)), addr, len, size, burst, 1'b1, 0, 1'b0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
        awid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00;
        awlock = 1'b0; awcache = 4'd0; awprot = 3'd0; awqos = 4'd0; awuser = 1'b0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wuser = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 1'b0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00;
        arlock = 2'b00; arcache = 4'd0; arprot = 3'd0; arqos = 4'd0; aruser = 1'b0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_fill();
        test_single();
        test_incr();
        test_wrap();
        test_strobe();
        test_protocol_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
